// File: rtl/delay_timer_prog.sv
// -----------------------------------------------------------------------------
// delay_timer_prog
// Programmable delay timer for the reaction-timer game.
//   * WIDTH-bit down-counter, decremented once every PRESCALE clock1 cycles
//   * one-shot or auto-reload, selected when start is accepted
//   * abort has priority over start, which has priority over counting
//   * done is a one-cycle pulse on each expiry, output_signal marks expiry,
//     busy is high while running, count shows the live counter value
// Optional build macro: DELAY_TIMER_RANDOM_EN
//   When defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11) adds a masked
//   random offset to delay_in on each accepted start (saturating sum).
//   When undefined, the load value is delay_in exactly and no LFSR exists.
// All outputs are driven straight from flops.
// -----------------------------------------------------------------------------
module delay_timer_prog #(
    parameter int               WIDTH     = 12,
    parameter int               PRESCALE  = 1,
    parameter logic [WIDTH-1:0] RAND_MASK = 12'h0FF,
    parameter logic [15:0]      SEED      = 16'hACE1
) (
    input  logic             clock1,
    input  logic             key,
    input  logic             start,
    input  logic             abort,
    input  logic             reload_mode,
    input  logic [WIDTH-1:0] delay_in,
    output logic             output_signal,
    output logic             done,
    output logic             busy,
    output logic [WIDTH-1:0] count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_EXPIRED = 2'b10
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    state_t           state_r;
    logic [WIDTH-1:0] counter_r;
    logic [WIDTH-1:0] load_r;
    logic             mode_r;
    logic             output_signal_r;
    logic             done_r;
    logic             busy_r;

    logic             accept_s;
    logic             tick_s;
    logic [WIDTH-1:0] load_s;

    // Saturating add used when the random offset is folded into the delay.
    function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[WIDTH]) begin
            return {WIDTH{1'b1}};
        end else begin
            return sum[WIDTH-1:0];
        end
    endfunction

    // Feedback bit for the 16-bit Fibonacci LFSR, taps 16,14,13,11.
    function automatic logic lfsr_feedback(input logic [15:0] v);
        return v[15] ^ v[13] ^ v[12] ^ v[10];
    endfunction

    // A start is accepted only when abort is not asserted on the same edge.
    always_comb begin
        accept_s = 1'b0;
        if (start && !abort) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Prescaler: only built when more than one cycle per tick is requested.
    // -------------------------------------------------------------------------
    if (PRESCALE > 1) begin : g_prescaler
        localparam int              PS_W    = $clog2(PRESCALE);
        localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
        localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);
        localparam logic [PS_W-1:0] PS_ZERO = {PS_W{1'b0}};

        logic [PS_W-1:0] prescale_r;

        // Cycle counter within one tick; held at zero outside RUN and on start/abort.
        always_ff @(posedge clock1 or posedge key) begin
            if (key) begin
                prescale_r <= PS_ZERO;
            end else if (abort || accept_s || (state_r != ST_RUN)) begin
                prescale_r <= PS_ZERO;
            end else if (prescale_r == PS_LAST) begin
                prescale_r <= PS_ZERO;
            end else begin
                prescale_r <= prescale_r + PS_ONE;
            end
        end

        // A tick occurs on the last cycle of each prescaler period while running.
        always_comb begin
            tick_s = 1'b0;
            if ((state_r == ST_RUN) && (prescale_r == PS_LAST)) begin
                tick_s = 1'b1;
            end else begin
                tick_s = 1'b0;
            end
        end
    end else begin : g_no_prescaler
        // Without a prescaler every running cycle is a tick.
        always_comb begin
            tick_s = 1'b0;
            if (state_r == ST_RUN) begin
                tick_s = 1'b1;
            end else begin
                tick_s = 1'b0;
            end
        end
    end

    // A zero seed would lock the LFSR in its all-zero state; this named
    // block marks that configuration and keeps both random parameters
    // referenced in every build.
    if ((SEED == 16'h0000) || (RAND_MASK == CNT_ZERO)) begin : g_random_cfg_degenerate
    end

    // -------------------------------------------------------------------------
    // Load value selection
    // -------------------------------------------------------------------------
`ifdef DELAY_TIMER_RANDOM_EN
    logic [15:0]      lfsr_r;
    logic [31:0]      lfsr_ext_s;
    logic [WIDTH-1:0] rand_s;

    // LFSR free-runs on every clock1 edge so start time picks the offset.
    always_ff @(posedge clock1 or posedge key) begin
        if (key) begin
            lfsr_r <= SEED;
        end else begin
            lfsr_r <= {lfsr_r[14:0], lfsr_feedback(lfsr_r)};
        end
    end

    // Randomised load: delay_in plus masked LFSR bits, saturating at all-ones.
    always_comb begin
        lfsr_ext_s = {16'h0000, lfsr_r};
        rand_s     = lfsr_ext_s[WIDTH-1:0] & RAND_MASK;
        load_s     = sat_add(delay_in, rand_s);
    end
`else
    // Deterministic load: exactly the requested delay.
    always_comb begin
        load_s = delay_in;
    end
`endif

    // -------------------------------------------------------------------------
    // Main FSM with registered outputs.
    // -------------------------------------------------------------------------
    // Controls state, counter, latched load/mode and all output flops.
    always_ff @(posedge clock1 or posedge key) begin
        if (key) begin
            state_r         <= ST_IDLE;
            counter_r       <= CNT_ZERO;
            load_r          <= CNT_ZERO;
            mode_r          <= 1'b0;
            output_signal_r <= 1'b0;
            done_r          <= 1'b0;
            busy_r          <= 1'b0;
        end else if (abort) begin
            state_r         <= ST_IDLE;
            counter_r       <= CNT_ZERO;
            output_signal_r <= 1'b0;
            done_r          <= 1'b0;
            busy_r          <= 1'b0;
        end else if (accept_s) begin
            load_r <= load_s;
            mode_r <= reload_mode;
            if (load_s != CNT_ZERO) begin
                state_r         <= ST_RUN;
                counter_r       <= load_s;
                output_signal_r <= 1'b0;
                done_r          <= 1'b0;
                busy_r          <= 1'b1;
            end else begin
                // Zero delay expires on the accepting edge itself.
                state_r         <= ST_EXPIRED;
                counter_r       <= CNT_ZERO;
                output_signal_r <= 1'b1;
                done_r          <= 1'b1;
                busy_r          <= 1'b0;
            end
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (tick_s) begin
                        // Counter values of 0 or 1 both expire, so it never wraps.
                        if (counter_r <= CNT_ONE) begin
                            done_r          <= 1'b1;
                            output_signal_r <= 1'b1;
                            if (mode_r) begin
                                state_r   <= ST_RUN;
                                counter_r <= load_r;
                                busy_r    <= 1'b1;
                            end else begin
                                state_r   <= ST_EXPIRED;
                                counter_r <= CNT_ZERO;
                                busy_r    <= 1'b0;
                            end
                        end else begin
                            counter_r       <= counter_r - CNT_ONE;
                            done_r          <= 1'b0;
                            output_signal_r <= 1'b0;
                            busy_r          <= 1'b1;
                        end
                    end else begin
                        done_r          <= 1'b0;
                        output_signal_r <= 1'b0;
                        busy_r          <= 1'b1;
                    end
                end
                ST_EXPIRED: begin
                    counter_r       <= CNT_ZERO;
                    output_signal_r <= 1'b1;
                    done_r          <= 1'b0;
                    busy_r          <= 1'b0;
                end
                ST_IDLE: begin
                    counter_r       <= CNT_ZERO;
                    output_signal_r <= 1'b0;
                    done_r          <= 1'b0;
                    busy_r          <= 1'b0;
                end
                default: begin
                    // Illegal encoding: recover to a quiet IDLE.
                    state_r         <= ST_IDLE;
                    counter_r       <= CNT_ZERO;
                    output_signal_r <= 1'b0;
                    done_r          <= 1'b0;
                    busy_r          <= 1'b0;
                end
            endcase
        end
    end

    assign output_signal = output_signal_r;
    assign done          = done_r;
    assign busy          = busy_r;
    assign count         = counter_r;

endmodule

// File: doc/delay_timer_prog.md
Name: delay_timer_prog

Overview:
- Parametrised programmable delay timer for the reaction-timer game; successor to the fixed 12-bit single-shot delay counter.
- Generalised width; prescaled tick; one-shot or auto-reload mode; abort and restart.
- Provides done pulse, busy flag and live count.
- Sits between the key/start logic and the LED/stimulus and reaction-measurement logic.

Parameters:
- WIDTH, 12, width of delay value and down-counter.
- PRESCALE, 1, clock1 cycles per counter decrement (>=1); PRESCALE=1 means no prescaler logic.
- RAND_MASK, 12'h0FF, mask applied to LFSR bits added to the delay (used only with RANDOM_EN).
- SEED, 16'hACE1, LFSR reset value, nonzero (used only with RANDOM_EN).

Ports:
- clock1  input  1  system clock, rising edge.
- key  input  1  asynchronous active-high reset.
- start  input  1  synchronous start/restart strobe.
- abort  input  1  synchronous abort strobe.
- reload_mode  input  1  0 = one-shot, 1 = auto-reload; sampled when start is accepted.
- delay_in  input  WIDTH  delay in ticks; sampled when start is accepted.
- output_signal  output  1  expiry indication.
- done  output  1  one-cycle pulse on each expiry.
- busy  output  1  high in RUN.
- count  output  WIDTH  current down-counter value.

Behaviour:
- Reset (key=1, async): state IDLE, counter=0, prescaler=0, latched mode=0, latched load=0. Outputs output_signal=0, done=0, busy=0, count=0.
- States: IDLE, RUN, EXPIRED. busy=1 exactly when state=RUN. All outputs are registered.
- Priority per edge: abort > start > counting.
- abort=1 in any state: next state IDLE; counter=0, prescaler=0, output_signal=0, done=0.
- Start accepted (start=1, abort=0) in any state:
  - load = delay_in; latch reload_mode; prescaler=0; output_signal=0.
  - If load≠0: next state RUN, counter=load.
  - If load=0: next state EXPIRED at that same edge, with done=1 and output_signal=1.
  - A start during RUN restarts cleanly; no done is issued for the abandoned run.
- RUN, per edge:
  - Prescaler increments. When it equals PRESCALE-1, it wraps to 0 and the counter decrements by 1.
  - When the counter goes 1→0 on a tick: done=1 at that edge.
  - One-shot: next state EXPIRED, output_signal=1.
  - Auto-reload: counter reloads from the latched load at that same edge, state stays RUN, output_signal=1 for that single cycle only.
- Latency: with load=N≥1, done/output_signal rise exactly N*PRESCALE rising edges after the edge that accepted start. Auto-reload period is N*PRESCALE cycles with no dead cycle.
- EXPIRED: output_signal held 1, done=0 after the first cycle, counter=0. Leave only via start or abort.
- Arithmetic: counter never wraps below 0. delay_in=all-ones is valid, giving (2^WIDTH-1)*PRESCALE cycles.
- Reset mid-run: immediate return to reset values; no done is issued.

Optional Feature:
- Macro: DELAY_TIMER_RANDOM_EN.
- Defined:
  - 16-bit Fibonacci LFSR (taps 16,14,13,11) reset to SEED, advances every clock1 edge.
  - On accepted start: load = delay_in + (lfsr[WIDTH-1:0] & RAND_MASK), saturating at 2^WIDTH-1.
  - The same randomised value is reused for auto-reload.
  - The load=0 rule applies to the final sum.
- Undefined: no LFSR; load = delay_in exactly.

Test Plan:
- Reset with PRESCALE=1, assert key mid-cycle -> all outputs 0 immediately (async); IDLE; busy=0.
- PRESCALE=4, delay_in=5, one-shot, start pulse -> busy=1 next cycle; done and output_signal rise exactly 20 edges after start; done low on the following cycle; output_signal stays 1; count=0.
- Auto-reload, PRESCALE=1, delay_in=3 -> done/output_signal 1-cycle pulses every 3 cycles for ≥4 periods; busy stays 1; abort -> IDLE, busy=0, no further pulses.
- delay_in=0 start -> EXPIRED at the accepting edge; done=1 for one cycle; output_signal=1.
- Restart at count=2 with delay_in=7, then abort and start asserted together -> abort wins, state IDLE; restart alone -> full 7*PRESCALE delay, no spurious done.
- DELAY_TIMER_RANDOM_EN, delay_in=12'hFFF, RAND_MASK=12'h0FF -> load saturates at 12'hFFF; two starts at different LFSR states with delay_in=10 give differing delays, each within 10..265 ticks.
